// File: rtl/axi_sram_arbiter.sv
// axi_sram_arbiter
//   Bridges NPORT SRAM-style request ports onto a single AXI3 master with one
//   transaction in flight. Each client gets its own done/err pulse, so a port
//   stalls only on its own access. The winning port index is used as AXI ID.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   req/we               per-port request (held until done) and write select
//   wstrb/addr/wdata     per-port packed write strobes, address, write data
//   rdata_o              read data of the last read beat, valid with done
//   done/err             one-cycle completion pulse and error flag, one-hot
//   busy                 transaction in flight
//   ar*/r*               AXI3 read address / read data channels
//   aw*/w*/b*            AXI3 write address / write data / write response;
//                        the W channel data and strobes are axi_wdata and
//                        axi_wstrb to keep them apart from the client ports
//
// state   | meaning
// S_IDLE  | waiting for a request; done/err pulse in the cycle after completion
// S_AR    | arvalid up, waiting for arready
// S_R     | rready up, collecting read beats until rlast
// S_WR    | awvalid/wvalid up, each drops on its own handshake
// S_B     | bready up, waiting for the write response
module axi_sram_arbiter #(
  parameter int NPORT     = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int IDW       = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      req,
  input  logic [NPORT-1:0]      we,
  input  logic [NPORT*DW/8-1:0] wstrb,
  input  logic [NPORT*AW-1:0]   addr,
  input  logic [NPORT*DW-1:0]   wdata,
  output logic [DW-1:0]         rdata_o,
  output logic [NPORT-1:0]      done,
  output logic [NPORT-1:0]      err,
  output logic                  busy,
  output logic [IDW-1:0]        arid,
  output logic [AW-1:0]         araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [IDW-1:0]        rid,
  input  logic [DW-1:0]         rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [IDW-1:0]        awid,
  output logic [AW-1:0]         awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [IDW-1:0]        wid,
  output logic [DW-1:0]         axi_wdata,
  output logic [DW/8-1:0]       axi_wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [IDW-1:0]        bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int SW = DW / 8;
  localparam int SZ = $clog2(SW);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;

  logic [2:0]       state;
  logic [PW-1:0]    rr_ptr, gnt_q, gnt_idx, ptr_eff;
  logic [AW-1:0]    addr_q, sel_addr;
  logic [DW-1:0]    wdata_q, sel_wdata;
  logic [SW-1:0]    wstrb_q, sel_wstrb;
  logic             sel_we, gnt_vld, grant, err_sticky;
  logic [NPORT-1:0] req_rot, gnt_oh;
  logic             aw_fin, w_fin;

  // Single outstanding transaction, so response IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  // Rotate the request vector so the search always starts at bit 0; in
  // fixed-priority mode the rotation is zero and port 0 wins.
  assign ptr_eff = (PRIO_MODE != 0) ? rr_ptr : '0;
  assign req_rot = NPORT'({req, req} >> ptr_eff);

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(ptr_eff) + i) % NPORT);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_we    = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (gnt_idx == PW'(p)) begin
        sel_addr  = addr[p*AW +: AW];
        sel_wdata = wdata[p*DW +: DW];
        sel_wstrb = wstrb[p*SW +: SW];
        sel_we    = we[p];
      end
    end
  end

  // The done cycle is an IDLE cycle in which no new grant is taken.
  assign grant  = (state == S_IDLE) && gnt_vld && !(|done);
  assign gnt_oh = NPORT'(1) << gnt_q;
  assign aw_fin = !awvalid || awready;
  assign w_fin  = !wvalid || wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      err_sticky <= 1'b0;
      rdata_o    <= '0;
      done       <= '0;
      err        <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            gnt_q      <= gnt_idx;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            wstrb_q    <= sel_wstrb;
            err_sticky <= 1'b0;
            rr_ptr     <= (int'(gnt_idx) == NPORT - 1) ? '0 : gnt_idx + PW'(1);
            if (sel_we) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR;
            end else begin
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid && rready) begin
            rdata_o <= rdata;
            if (rresp != 2'b00) err_sticky <= 1'b1;
            if (rlast) begin
              rready <= 1'b0;
              done   <= gnt_oh;
              err    <= (err_sticky || (rresp != 2'b00)) ? gnt_oh : '0;
              state  <= S_IDLE;
            end
          end
        end
        S_WR: begin
          if (aw_fin && w_fin) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b1;
            state   <= S_B;
          end else begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
          end
        end
        S_B: begin
          if (bvalid && bready) begin
            bready <= 1'b0;
            done   <= gnt_oh;
            err    <= (bresp != 2'b00) ? gnt_oh : '0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign arid      = IDW'(gnt_q);
  assign araddr    = addr_q;
  assign arlen     = 4'd0;
  assign arsize    = 3'(SZ);
  assign arburst   = 2'b01;
  assign arlock    = 2'b00;
  assign arcache   = 4'd0;
  assign arprot    = 3'd0;
  assign awid      = IDW'(gnt_q);
  assign awaddr    = addr_q;
  assign awlen     = 4'd0;
  assign awsize    = 3'(SZ);
  assign awburst   = 2'b01;
  assign awlock    = 2'b00;
  assign awcache   = 4'd0;
  assign awprot    = 3'd0;
  assign wid       = awid;
  assign axi_wdata = wdata_q;
  assign axi_wstrb = wstrb_q;
  assign wlast     = wvalid;

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Randomized bench for axi_sram_arbiter: two 3-port instances, instance 0
// fixed priority, instance 1 round robin. Random clients and a random-latency
// AXI slave; a transaction-level model predicts grants, handshakes and
// completions cycle by cycle.
module tb_axi_sram_arbiter;
  localparam int NP   = 3;
  localparam int NI   = 2;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn_v [NI];
  logic [NP-1:0]   req_v [NI], we_v [NI];
  logic [NP*4-1:0] wstrb_v [NI];
  logic [NP*32-1:0] addr_v [NI], wdata_v [NI];
  logic [31:0]     rdata_o_v [NI];
  logic [NP-1:0]   done_v [NI], err_v [NI];
  logic            busy_v [NI];
  logic [3:0]  arid_v [NI], arlen_v [NI], arcache_v [NI], rid_v [NI];
  logic [3:0]  awid_v [NI], awlen_v [NI], awcache_v [NI], wid_v [NI], bid_v [NI];
  logic [31:0] araddr_v [NI], awaddr_v [NI], rdata_v [NI], axwdata_v [NI];
  logic [3:0]  axwstrb_v [NI];
  logic [2:0]  arsize_v [NI], arprot_v [NI], awsize_v [NI], awprot_v [NI];
  logic [1:0]  arburst_v [NI], arlock_v [NI], awburst_v [NI], awlock_v [NI];
  logic [1:0]  rresp_v [NI], bresp_v [NI];
  logic arvalid_v [NI], arready_v [NI], rlast_v [NI], rvalid_v [NI], rready_v [NI];
  logic awvalid_v [NI], awready_v [NI], wlast_v [NI], wvalid_v [NI], wready_v [NI];
  logic bvalid_v [NI], bready_v [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    axi_sram_arbiter #(.NPORT(NP), .AW(32), .DW(32), .IDW(4), .PRIO_MODE(k)) u_dut (
      .clk(clk), .resetn(resetn_v[k]),
      .req(req_v[k]), .we(we_v[k]), .wstrb(wstrb_v[k]), .addr(addr_v[k]), .wdata(wdata_v[k]),
      .rdata_o(rdata_o_v[k]), .done(done_v[k]), .err(err_v[k]), .busy(busy_v[k]),
      .arid(arid_v[k]), .araddr(araddr_v[k]), .arlen(arlen_v[k]), .arsize(arsize_v[k]),
      .arburst(arburst_v[k]), .arlock(arlock_v[k]), .arcache(arcache_v[k]), .arprot(arprot_v[k]),
      .arvalid(arvalid_v[k]), .arready(arready_v[k]),
      .rid(rid_v[k]), .rdata(rdata_v[k]), .rresp(rresp_v[k]), .rlast(rlast_v[k]),
      .rvalid(rvalid_v[k]), .rready(rready_v[k]),
      .awid(awid_v[k]), .awaddr(awaddr_v[k]), .awlen(awlen_v[k]), .awsize(awsize_v[k]),
      .awburst(awburst_v[k]), .awlock(awlock_v[k]), .awcache(awcache_v[k]), .awprot(awprot_v[k]),
      .awvalid(awvalid_v[k]), .awready(awready_v[k]),
      .wid(wid_v[k]), .axi_wdata(axwdata_v[k]), .axi_wstrb(axwstrb_v[k]), .wlast(wlast_v[k]),
      .wvalid(wvalid_v[k]), .wready(wready_v[k]),
      .bid(bid_v[k]), .bresp(bresp_v[k]), .bvalid(bvalid_v[k]), .bready(bready_v[k])
    );
  end

  // transaction phase seen from the slave side: 0 none, 1 addr read, 2 read data,
  // 3 write addr/data, 4 write response
  int          phase [NI], tx_port [NI], beats [NI], ptr [NI], ncomp [NI];
  int          idle_cnt [NI][NP];
  logic        inflight [NI], exp_done [NI], exp_err [NI], aw_hs [NI], w_hs [NI];
  logic        rst_pend [NI], rst_used [NI], tx_we [NI];
  logic [31:0] tx_addr [NI], tx_wdata [NI], rd_model [NI];
  logic [3:0]  tx_wstrb [NI];
  int          cyc, cur_k;
  int          n_vec = 0, n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s inst=%0d cyc=%0d: got %0h expected %0h", tag, cur_k, cyc, obs, exp);
    end
  endtask

  function automatic int arb(input logic [NP-1:0] r, input int p, input int mode);
    for (int i = 0; i < NP; i++) begin
      int j;
      j = (mode == 0) ? i : (p + i) % NP;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic rand_port(input int k, input int p);
    we_v[k][p]             = 1'($urandom);
    addr_v[k][p*32 +: 32]  = $urandom & 32'hFFFF_FFFC;
    wdata_v[k][p*32 +: 32] = $urandom;
    wstrb_v[k][p*4 +: 4]   = 4'($urandom);
  endtask

  function automatic logic [4:0] hs_vec(input int k);
    return {arvalid_v[k], awvalid_v[k], wvalid_v[k], rready_v[k], bready_v[k]};
  endfunction

  task automatic model_reset(input int k);
    inflight[k] = 1'b0; exp_done[k] = 1'b0; exp_err[k] = 1'b0; phase[k] = 0;
    ptr[k] = 0; rd_model[k] = '0; aw_hs[k] = 1'b0; w_hs[k] = 1'b0;
  endtask

  task automatic tick(input int k);
    logic [NP-1:0] oh;
    logic          done_tick, rst_now;
    int            g;
    cur_k     = k;
    done_tick = 1'b0;
    rst_now   = 1'b0;
    oh        = NP'(1) << tx_port[k];
    rvalid_v[k]  = 1'b0; rlast_v[k] = 1'b0; bvalid_v[k] = 1'b0;
    arready_v[k] = ($urandom % 3) == 0;
    awready_v[k] = ($urandom % 3) == 0;
    wready_v[k]  = ($urandom % 3) == 0;

    if (rst_pend[k]) begin
      chk("rst_done_err", {done_v[k], err_v[k]}, 0);
      chk("rst_busy", busy_v[k], 0);
      chk("rst_handshake", hs_vec(k), 0);
      chk("rst_rdata", rdata_o_v[k], 0);
      resetn_v[k] = 1'b1;
      rst_pend[k] = 1'b0;
      model_reset(k);
    end else begin
      chk("busy", busy_v[k], inflight[k] && !exp_done[k]);
      chk("rdata_o", rdata_o_v[k], rd_model[k]);
      if (exp_done[k]) begin
        chk("done", done_v[k], oh);
        chk("err", err_v[k], exp_err[k] ? oh : '0);
        chk("done_handshake", hs_vec(k), 0);
        exp_done[k] = 1'b0; inflight[k] = 1'b0; phase[k] = 0; done_tick = 1'b1;
        ncomp[k]++;
        // requester either drops req or keeps it up for a repeat access
        if (req_v[k][tx_port[k]] && (($urandom % 2) == 0)) begin
          req_v[k][tx_port[k]] = 1'b0;
          idle_cnt[k][tx_port[k]] = $urandom_range(0, 4);
        end
      end else begin
        chk("no_done", {done_v[k], err_v[k]}, 0);
        case (phase[k])
          1: begin
            chk("ar_handshake", hs_vec(k), 5'b10000);
            chk("araddr", araddr_v[k], tx_addr[k]);
            chk("arid", arid_v[k], tx_port[k]);
            chk("ar_attr", {arlen_v[k], arsize_v[k], arburst_v[k], arlock_v[k], arcache_v[k], arprot_v[k]},
                {4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
            if (arready_v[k]) phase[k] = 2;
          end
          2: begin
            chk("r_handshake", hs_vec(k), 5'b00010);
            if (beats[k] > 0 && ($urandom % 3) != 0) begin
              rvalid_v[k] = 1'b1;
              rdata_v[k]  = $urandom;
              rresp_v[k]  = (($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
              rlast_v[k]  = (beats[k] == 1);
              rid_v[k]    = 4'(tx_port[k]);
              if (!rst_used[k] && cyc > 800 + 1200 * k) begin
                // reset lands on the edge where this beat would be taken
                resetn_v[k] = 1'b0; rst_pend[k] = 1'b1; rst_used[k] = 1'b1; rst_now = 1'b1;
              end else begin
                rd_model[k] = rdata_v[k];
                if (rresp_v[k] != 2'b00) exp_err[k] = 1'b1;
                beats[k]--;
                if (beats[k] == 0) exp_done[k] = 1'b1;
              end
            end
          end
          3: begin
            chk("wr_ctl", {arvalid_v[k], rready_v[k], bready_v[k]}, 0);
            chk("awvalid", awvalid_v[k], !aw_hs[k]);
            chk("wvalid", wvalid_v[k], !w_hs[k]);
            chk("wlast", wlast_v[k], !w_hs[k]);
            if (!aw_hs[k]) begin
              chk("awaddr", awaddr_v[k], tx_addr[k]);
              chk("awid", awid_v[k], tx_port[k]);
              chk("aw_attr", {awlen_v[k], awsize_v[k], awburst_v[k], awlock_v[k], awcache_v[k], awprot_v[k]},
                  {4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
            end
            if (!w_hs[k]) begin
              chk("wdata", axwdata_v[k], tx_wdata[k]);
              chk("wstrb", axwstrb_v[k], tx_wstrb[k]);
              chk("wid", wid_v[k], tx_port[k]);
            end
            if (awready_v[k]) aw_hs[k] = 1'b1;
            if (wready_v[k])  w_hs[k]  = 1'b1;
            if (aw_hs[k] && w_hs[k]) phase[k] = 4;
          end
          4: begin
            chk("b_handshake", hs_vec(k), 5'b00001);
            if (($urandom % 3) != 0) begin
              bvalid_v[k] = 1'b1;
              bresp_v[k]  = (($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
              bid_v[k]    = 4'(tx_port[k]);
              exp_err[k]  = (bresp_v[k] != 2'b00);
              exp_done[k] = 1'b1;
            end
          end
          default: chk("idle_handshake", hs_vec(k), 0);
        endcase
      end
    end

    for (int p = 0; p < NP; p++) begin
      if (!req_v[k][p]) begin
        if (idle_cnt[k][p] > 0) idle_cnt[k][p]--;
        else begin
          rand_port(k, p);
          req_v[k][p] = 1'b1;
        end
      end else if (($urandom % 16) == 0) begin
        rand_port(k, p);
      end
    end
    if (inflight[k] && !exp_done[k] && !rst_now && (($urandom % 40) == 0)) begin
      req_v[k][tx_port[k]] = 1'b0;
      idle_cnt[k][tx_port[k]] = $urandom_range(0, 4);
    end

    if (!inflight[k] && !done_tick && !rst_now) begin
      g = arb(req_v[k], ptr[k], k);
      if (g >= 0) begin
        tx_port[k]  = g;
        tx_we[k]    = we_v[k][g];
        tx_addr[k]  = addr_v[k][g*32 +: 32];
        tx_wdata[k] = wdata_v[k][g*32 +: 32];
        tx_wstrb[k] = wstrb_v[k][g*4 +: 4];
        inflight[k] = 1'b1;
        exp_err[k]  = 1'b0;
        aw_hs[k]    = 1'b0;
        w_hs[k]     = 1'b0;
        beats[k]    = $urandom_range(1, 2);
        phase[k]    = tx_we[k] ? 3 : 1;
        ptr[k]      = (g + 1) % NP;
      end
    end
  endtask

  initial begin
    cyc = 0;
    for (int k = 0; k < NI; k++) begin
      resetn_v[k] = 1'b0;
      req_v[k] = '0; we_v[k] = '0; wstrb_v[k] = '0; addr_v[k] = '0; wdata_v[k] = '0;
      arready_v[k] = 1'b0; awready_v[k] = 1'b0; wready_v[k] = 1'b0;
      rid_v[k] = '0; rdata_v[k] = '0; rresp_v[k] = '0; rlast_v[k] = 1'b0; rvalid_v[k] = 1'b0;
      bid_v[k] = '0; bresp_v[k] = '0; bvalid_v[k] = 1'b0;
      rst_pend[k] = 1'b0; rst_used[k] = 1'b0; ncomp[k] = 0; tx_port[k] = 0; beats[k] = 0;
      model_reset(k);
      for (int p = 0; p < NP; p++) idle_cnt[k][p] = $urandom_range(0, 6);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      cur_k = k;
      chk("reset_done_err", {done_v[k], err_v[k]}, 0);
      chk("reset_busy", busy_v[k], 0);
      chk("reset_handshake", hs_vec(k), 0);
      chk("reset_rdata", rdata_o_v[k], 0);
      resetn_v[k] = 1'b1;
    end
    for (cyc = 1; cyc <= NCYC; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) tick(k);
    end
    for (int k = 0; k < NI; k++) begin
      cur_k = k;
      chk("progress", ncomp[k] > 100, 1);
      chk("reset_exercised", rst_used[k] && !rst_pend[k], 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
